// File: rtl/audio_clk_gen.sv
// audio_clk_gen: programmable BCLK/LRCLK generator with clk-domain strobes.
// Ports: clk, reset (sync, active-high), en, div_in/div_wr/div_busy (divisor),
//        bclk, lrclk, bclk_rise, bclk_fall, frame_start (one-clk strobes).
// Build option: define AUDIO_CLK_I2S_DELAY_EN for I2S (one-bclk-early) lrclk.
module audio_clk_gen #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 11,
    parameter int WORD_BITS   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_wr,
    output logic             div_busy,
    output logic             bclk,
    output logic             lrclk,
    output logic             bclk_rise,
    output logic             bclk_fall,
    output logic             frame_start
);

    localparam int BW = $clog2(2 * WORD_BITS);
    localparam logic [BW-1:0] LAST = BW'(2 * WORD_BITS - 1);
    localparam logic [BW-1:0] WB   = BW'(WORD_BITS);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             bclk_q, bclk_d;
    logic             lr_q, lr_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             frame_q, frame_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [BW-1:0]    bit_nxt;
    logic             lr_nxt;

    always_comb begin
        bit_nxt = (bit_q == LAST) ? '0 : bit_q + 1'b1;
`ifdef AUDIO_CLK_I2S_DELAY_EN
        lr_nxt = (bit_nxt >= WB - 1'b1) && (bit_nxt != LAST);
`else
        lr_nxt = (bit_nxt >= WB);
`endif
    end

    always_comb begin
        cnt_d   = cnt_q;
        act_d   = act_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        bclk_d  = bclk_q;
        lr_d    = lr_q;
        bit_d   = bit_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        frame_d = 1'b0;
        if (!en) begin
            bclk_d = 1'b0;
            lr_d   = 1'b0;
            bit_d  = '0;
            cnt_d  = act_q;
            // Idle: a write takes effect at once; any older pending value
            // is superseded.
            if (div_wr) begin
                act_d  = div_in;
                cnt_d  = div_in;
                busy_d = 1'b0;
            end
        end else begin
            if (cnt_q == '0) begin
                bclk_d = ~bclk_q;
                // Swap divisor only at a half-period boundary: no runts.
                if (busy_q) begin
                    act_d  = pend_q;
                    cnt_d  = pend_q;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = act_q;
                end
                if (bclk_q) begin
                    fall_d  = 1'b1;
                    bit_d   = bit_nxt;
                    lr_d    = lr_nxt;
                    frame_d = (bit_nxt == '0);
                end else begin
                    rise_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            // Evaluated after the reload so a coincident write waits
            // for the following reload.
            if (div_wr) begin
                pend_d = div_in;
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= DIV_RST;
            act_q   <= DIV_RST;
            pend_q  <= DIV_RST;
            busy_q  <= 1'b0;
            bclk_q  <= 1'b0;
            lr_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            frame_q <= 1'b0;
            bit_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            bclk_q  <= bclk_d;
            lr_q    <= lr_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
        end
    end

    assign div_busy    = busy_q;
    assign bclk        = bclk_q;
    assign lrclk       = lr_q;
    assign bclk_rise   = rise_q;
    assign bclk_fall   = fall_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_audio_clk_gen.sv
// tb_audio_clk_gen: random stimulus against a half-period-count model.
// Ports of DUT: see rtl/audio_clk_gen.sv.
module tb_audio_clk_gen;

    localparam int CNT_W = 16;
    localparam int DEF   = 11;
    localparam int WB    = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic             div_wr = 1'b0;
    logic             div_busy, bclk, lrclk;
    logic             bclk_rise, bclk_fall, frame_start;

    int total = 0;
    int bad   = 0;

    audio_clk_gen #(
        .CNT_W(CNT_W), .DIV_DEFAULT(DEF), .WORD_BITS(WB)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .div_in(div_in), .div_wr(div_wr), .div_busy(div_busy),
        .bclk(bclk), .lrclk(lrclk), .bclk_rise(bclk_rise),
        .bclk_fall(bclk_fall), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Model: number of bclk toggles since enable, and enabled edges left
    // until the next toggle. Everything else is arithmetic on those.
    int m_left = DEF + 1;
    int m_halfs = 0;
    int m_act = DEF;
    int m_pend = 0;
    bit m_busy = 0;
    bit m_tog = 0;

    always @(posedge clk) begin
        m_tog = 0;
        if (reset) begin
            m_act = DEF; m_busy = 0; m_halfs = 0; m_left = DEF + 1;
        end else if (!en) begin
            m_halfs = 0;
            if (div_wr) begin
                m_act = int'(div_in); m_busy = 0;
            end
            m_left = m_act + 1;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_tog = 1;
                m_halfs++;
                if (m_busy) begin
                    m_act = m_pend; m_busy = 0;
                end
                m_left = m_act + 1;
            end
            if (div_wr) begin
                m_pend = int'(div_in); m_busy = 1;
            end
        end
    end

    function automatic int exp_outs();
        int bi;
        bit b, lr, r, f, fr;
        bi = (m_halfs / 2) % (2 * WB);
        b  = m_halfs[0];
        r  = m_tog && b;
        f  = m_tog && !b;
`ifdef AUDIO_CLK_I2S_DELAY_EN
        lr = (bi >= WB - 1) && (bi != 2 * WB - 1);
`else
        lr = (bi >= WB);
`endif
        fr = f && (bi == 0);
        return int'({b, lr, r, f, fr, m_busy});
    endfunction

    bit run_chk = 0;
    always @(negedge clk) begin
        if (run_chk)
            chk("outs", int'({bclk, lrclk, bclk_rise, bclk_fall,
                              frame_start, div_busy}), exp_outs());
    end

    int n;
    int lr_hi;
    int frames;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({bclk, lrclk, bclk_rise, bclk_fall,
                                frame_start, div_busy}), 0);
        reset = 1'b0;
        run_chk = 1;
        @(negedge clk);
        en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bclk_rise && n < 100);
        chk("first_rise", n, DEF + 1);
        @(negedge clk);
        chk("rise_width", int'(bclk_rise), 0);

        // Three frames at default divisor: count lrclk-high bit periods.
        lr_hi = 0; frames = 0; n = 0;
        while (frames < 3 && n < 6000) begin
            @(negedge clk);
            n++;
            if (bclk_fall && lrclk) lr_hi++;
            if (frame_start) frames++;
        end
        chk("frames_seen", frames, 3);
        chk("lr_high_bits", lr_hi, 3 * WB);

        // Divisor 0: bclk toggles every clk.
        div_in = '0; div_wr = 1'b1;
        @(negedge clk);
        div_wr = 1'b0;
        n = 0;
        while (!bclk_rise && n < 100) begin
            @(negedge clk); n++;
        end
        repeat (2) @(negedge clk);
        chk("div0_busy", int'(div_busy), 0);
        for (int i = 0; i < 4; i++) begin
            chk("div0_alt", int'({bclk_rise, bclk_fall}),
                int'({bclk, ~bclk}));
            @(negedge clk);
        end

        // Random stimulus.
        for (int c = 0; c < 30000; c++) begin
            reset  = ($urandom_range(0, 7999) == 0);
            en     = ($urandom_range(0, 1499) != 0);
            div_wr = ($urandom_range(0, 49) == 0);
            div_in = CNT_W'($urandom_range(0, 3));
            @(negedge clk);
        end
        reset = 1'b0; en = 1'b1; div_wr = 1'b0;
        repeat (20) @(negedge clk);
        run_chk = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
